wind_pattern_gen: RTL and testbench

WIND_PATTERN_GEN -- requirements
Module: wind_pattern_gen

---
 rtl/wind_pattern_gen.sv | 120 ++++++++++++
 tb/tb_wind_pattern_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wind_pattern_gen.sv
// Runway wind-indicator light pattern generator: calm alternation or a one-hot sweep per step.
// Optional build macro WIND_CHANGE_FLAG_EN adds the mode_changed output.
module wind_pattern_gen #(
  parameter int N        = 3,
  parameter int STEP_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   mode,
  output logic [N-1:0] lights,
  output logic         step
`ifdef WIND_CHANGE_FLAG_EN
  ,
  output logic         mode_changed
`endif
);

  typedef enum logic [1:0] {
    MODE_CALM  = 2'b00,
    MODE_RTL   = 2'b01,
    MODE_LTR   = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  function automatic logic [N-1:0] alt_pattern(input logic odd);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      p[i] = odd ? (i % 2 == 1) : (i % 2 == 0);
    end
    return p;
  endfunction

  localparam logic [N-1:0] CALM_A     = alt_pattern(1'b0);
  localparam logic [N-1:0] CALM_B     = alt_pattern(1'b1);
  localparam logic [N-1:0] LEFT_ONLY  = N'(1) << (N - 1);
  localparam logic [N-1:0] RIGHT_ONLY = N'(1);
  localparam logic [15:0]  LAST_COUNT = 16'(STEP_DIV - 1);

  logic [15:0]  count_q, count_d;
  logic [N-1:0] lights_q, lights_d;
  logic         step_q, step_d;
  logic [N-1:0] next_pattern;
  logic         tick;
  logic         one_hot;
  mode_e        mode_sel;

  assign mode_sel = mode_e'(mode);
  assign one_hot  = $onehot(lights_q);
  assign tick     = enable && (count_q == LAST_COUNT);

  always_comb begin
    next_pattern = lights_q;
    unique case (mode_sel)
      MODE_CALM: next_pattern = (lights_q == CALM_A) ? CALM_B : CALM_A;
      MODE_LTR:  next_pattern = one_hot ? {lights_q[0], lights_q[N-1:1]} : LEFT_ONLY;
      MODE_RTL:  next_pattern = one_hot ? {lights_q[N-2:0], lights_q[N-1]} : RIGHT_ONLY;
      MODE_HOLD: next_pattern = lights_q;
      default:   next_pattern = lights_q;
    endcase
  end

  // Timer and lights freeze while enable is low; step only pulses on a real update.
  always_comb begin
    count_d  = count_q;
    lights_d = lights_q;
    step_d   = 1'b0;
    if (enable) begin
      count_d = tick ? 16'd0 : count_q + 16'd1;
    end
    if (tick) begin
      lights_d = next_pattern;
      step_d   = (mode_sel != MODE_HOLD);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 16'd0;
      lights_q <= CALM_A;
      step_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      lights_q <= lights_d;
      step_q   <= step_d;
    end
  end

  assign lights = lights_q;
  assign step   = step_q;

`ifdef WIND_CHANGE_FLAG_EN
  // Last mode applied at a step event; reset behaves as if calm had been applied.
  logic [1:0] last_mode_q, last_mode_d;
  logic       changed_q, changed_d;

  always_comb begin
    last_mode_d = last_mode_q;
    changed_d   = 1'b0;
    if (tick) begin
      last_mode_d = mode;
      changed_d   = (mode_sel != MODE_HOLD) && (mode != last_mode_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_mode_q <= 2'b00;
      changed_q   <= 1'b0;
    end else begin
      last_mode_q <= last_mode_d;
      changed_q   <= changed_d;
    end
  end

  assign mode_changed = changed_q;
`endif

endmodule

// File: tb/tb_wind_pattern_gen.sv
// Directed bench for wind_pattern_gen: several parameterisations share one set of inputs.
module tb_wind_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [2:0] lights_a, lights_d, lights_e;
  logic [4:0] lights_b;
  logic [3:0] lights_c;
  logic       step_a, step_b, step_c, step_d, step_e;
`ifdef WIND_CHANGE_FLAG_EN
  logic       mc_a, mc_b, mc_c, mc_d, mc_e;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wind_pattern_gen #(.N(3), .STEP_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lights(lights_a), .step(step_a)
`ifdef WIND_CHANGE_FLAG_EN
    , .mode_changed(mc_a)
`endif
  );
  wind_pattern_gen #(.N(5), .STEP_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lights(lights_b), .step(step_b)
`ifdef WIND_CHANGE_FLAG_EN
    , .mode_changed(mc_b)
`endif
  );
  wind_pattern_gen #(.N(4), .STEP_DIV(1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lights(lights_c), .step(step_c)
`ifdef WIND_CHANGE_FLAG_EN
    , .mode_changed(mc_c)
`endif
  );
  wind_pattern_gen #(.N(3), .STEP_DIV(4)) dut_d (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lights(lights_d), .step(step_d)
`ifdef WIND_CHANGE_FLAG_EN
    , .mode_changed(mc_d)
`endif
  );
  wind_pattern_gen #(.N(3), .STEP_DIV(3)) dut_e (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .lights(lights_e), .step(step_e)
`ifdef WIND_CHANGE_FLAG_EN
    , .mode_changed(mc_e)
`endif
  );

  // Reset is released on a falling edge so the next rising edge is the first counted one.
  task automatic start(input logic [1:0] m);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    mode   = m;
    @(negedge clk);
    reset  = 1'b1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (lights_a !== 3'b101 || step_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_n3: got %b/%b expected 101/0", lights_a, step_a);
    end
    tests_run++;
    if (lights_c !== 4'b0101 || lights_b !== 5'b10101) begin
      tests_failed++;
      $display("[TB] FAIL reset_n4_n5: got %b %b expected 0101 10101", lights_c, lights_b);
    end
  endtask

  task automatic test_calm();
    logic [2:0] exp3 [0:3] = '{3'b010, 3'b101, 3'b010, 3'b101};
    logic [3:0] exp4 [0:3] = '{4'b1010, 4'b0101, 4'b1010, 4'b0101};
    start(2'b00);
    for (int i = 0; i < 4; i++) begin
      edge_sample();
      tests_run++;
      if (lights_a !== exp3[i] || step_a !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL calm_n3[%0d]: got %b/%b expected %b/1", i, lights_a, step_a, exp3[i]);
      end
      tests_run++;
      if (lights_c !== exp4[i]) begin
        tests_failed++;
        $display("[TB] FAIL calm_n4[%0d]: got %b expected %b", i, lights_c, exp4[i]);
      end
    end
  endtask

  // Six left-to-right steps wrap once, then a reversal shifts from the current position.
  task automatic test_sweep_reversal();
    logic [4:0] exp5 [0:8] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000,
                               5'b00001, 5'b00010, 5'b00100};
    start(2'b10);
    for (int i = 0; i < 9; i++) begin
      if (i == 6) mode = 2'b01;
      edge_sample();
      tests_run++;
      if (lights_b !== exp5[i] || step_b !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL sweep_n5[%0d]: got %b/%b expected %b/1", i, lights_b, step_b, exp5[i]);
      end
    end
  endtask

  task automatic test_slow_step();
    logic [2:0] seq [0:4] = '{3'b101, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] exp_l;
    logic       exp_s;
    start(2'b01);
    for (int e = 1; e <= 16; e++) begin
      edge_sample();
      exp_l = seq[e / 4];
      exp_s = (e % 4 == 0);
      tests_run++;
      if (lights_d !== exp_l || step_d !== exp_s) begin
        tests_failed++;
        $display("[TB] FAIL slow_step[%0d]: got %b/%b expected %b/%b", e, lights_d, step_d, exp_l, exp_s);
      end
    end
  endtask

  task automatic test_hold_freeze();
    start(2'b01);
    edge_sample();
    edge_sample();
    tests_run++;
    if (lights_c !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL hold_setup: got %b expected 0010", lights_c);
    end
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) enable = 1'b0;
      edge_sample();
      tests_run++;
      if (lights_c !== 4'b0010 || step_c !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold_freeze[%0d]: got %b/%b expected 0010/0", i, lights_c, step_c);
      end
    end
    enable = 1'b1;
    mode   = 2'b10;
    edge_sample();
    tests_run++;
    if (lights_c !== 4'b0001 || step_c !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hold_resume: got %b/%b expected 0001/1", lights_c, step_c);
    end
  endtask

  // Two enabled edges, three frozen, then the step lands on the second enabled edge after.
  task automatic test_enable_freeze();
    start(2'b01);
    edge_sample();
    edge_sample();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) edge_sample();
    tests_run++;
    if (lights_d !== 3'b101 || step_d !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL freeze_hold: got %b/%b expected 101/0", lights_d, step_d);
    end
    enable = 1'b1;
    edge_sample();
    tests_run++;
    if (lights_d !== 3'b101 || step_d !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL freeze_resume1: got %b/%b expected 101/0", lights_d, step_d);
    end
    edge_sample();
    tests_run++;
    if (lights_d !== 3'b001 || step_d !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL freeze_resume2: got %b/%b expected 001/1", lights_d, step_d);
    end
  endtask

  task automatic test_async_reset();
    start(2'b01);
    for (int i = 0; i < 6; i++) edge_sample();
    tests_run++;
    if (lights_e !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL async_setup: got %b expected 010", lights_e);
    end
    edge_sample();
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (lights_e !== 3'b101 || step_e !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %b/%b expected 101/0", lights_e, step_e);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      edge_sample();
      tests_run++;
      if (lights_e !== (e == 3 ? 3'b001 : 3'b101) || step_e !== (e == 3)) begin
        tests_failed++;
        $display("[TB] FAIL async_release[%0d]: got %b/%b", e, lights_e, step_e);
      end
    end
  endtask

`ifdef WIND_CHANGE_FLAG_EN
  task automatic test_mode_flag();
    logic [1:0] modes [0:4] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01};
    logic       flags [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    start(2'b00);
    for (int i = 0; i < 5; i++) begin
      mode = modes[i];
      edge_sample();
      tests_run++;
      if (mc_a !== flags[i] || step_a !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL mode_flag[%0d]: got %b/%b expected %b/1", i, mc_a, step_a, flags[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_calm();
    test_sweep_reversal();
    test_slow_step();
    test_hold_freeze();
    test_enable_freeze();
    test_async_reset();
`ifdef WIND_CHANGE_FLAG_EN
    test_mode_flag();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
